decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe_if.sv | 34 +++
 rtl/decode_pipe.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/decode_pipe_if.sv
// Handshake and operand bus for the decode pipeline stage.
// The master side feeds instructions and writeback; the slave side is the stage itself.
interface decode_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc_plus4;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [4:0]        rt_idx;
  logic [4:0]        rd_idx;
  logic [31:0]       ins_out;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] pc_plus4_out;

  modport master (
    output in_valid, instruction, pc_plus4, flush, wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, rd1, rd2, rt_idx, rd_idx, ins_out, imm_ext, pc_plus4_out
  );

  modport slave (
    input  in_valid, instruction, pc_plus4, flush, wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, rd1, rd2, rt_idx, rd_idx, ins_out, imm_ext, pc_plus4_out
  );
endinterface

// File: rtl/decode_pipe.sv
// Single-entry decode stage: register file read with writeback bypass,
// immediate extension and a valid/ready output register with flush.
module decode_pipe #(
  parameter int DATA_W        = 32,
  parameter int REG_COUNT     = 32,
  parameter bit INIT_IDENTITY = 1'b1,
  parameter bit ZERO_REG      = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  decode_pipe_if.slave bus
);

  localparam int              ADDR_W    = $clog2(REG_COUNT);
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(REG_COUNT);

  logic [DATA_W-1:0] r_regs [REG_COUNT];

  logic              r_out_valid;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [4:0]        r_rt_idx;
  logic [4:0]        r_rd_idx;
  logic [31:0]       r_ins;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc_plus4;

  logic              w_in_ready;
  logic              w_capture;
  logic              w_wr_commit;
  logic [ADDR_W-1:0] w_rs_addr;
  logic [ADDR_W-1:0] w_rt_addr;
  logic [DATA_W-1:0] w_rs_stored;
  logic [DATA_W-1:0] w_rt_stored;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [15:0]       w_imm16;
  logic [5:0]        w_opcode;
  logic [DATA_W-1:0] w_imm;

  // Non-power-of-two register counts leave some encodings without a register.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    addr_in_range = ({1'b0, addr} < REG_LIMIT);
  endfunction

  function automatic logic [DATA_W-1:0] select_operand(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              commit,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (ZERO_REG && (addr == '0)) begin
      select_operand = '0;
    end else if (commit && (waddr == addr)) begin
      select_operand = wdata;
    end else begin
      select_operand = stored;
    end
  endfunction

  assign w_in_ready  = !r_out_valid || bus.out_ready;
  assign w_capture   = bus.in_valid && w_in_ready && !bus.flush;
  assign w_wr_commit = bus.wr_en && addr_in_range(bus.wr_addr)
                       && !(ZERO_REG && (bus.wr_addr == '0));

  assign w_rs_addr   = bus.instruction[21 +: ADDR_W];
  assign w_rt_addr   = bus.instruction[16 +: ADDR_W];
  assign w_rs_stored = addr_in_range(w_rs_addr) ? r_regs[w_rs_addr] : '0;
  assign w_rt_stored = addr_in_range(w_rt_addr) ? r_regs[w_rt_addr] : '0;
  assign w_imm16     = bus.instruction[15:0];
  assign w_opcode    = bus.instruction[31:26];

  // Operand selection with same-cycle writeback forwarding
  always_comb begin
    w_rd1 = select_operand(w_rs_addr, w_rs_stored, w_wr_commit, bus.wr_addr, bus.wr_data);
    w_rd2 = select_operand(w_rt_addr, w_rt_stored, w_wr_commit, bus.wr_addr, bus.wr_data);
  end

  // Immediate extension: logical ops zero-extend, lui shifts up, rest sign-extend
  always_comb begin
    w_imm = '0;
    case (w_opcode)
      6'h0C, 6'h0D, 6'h0E: w_imm = DATA_W'(w_imm16);
      6'h0F:               w_imm = DATA_W'({w_imm16, 16'h0000});
      default:             w_imm = DATA_W'($signed(w_imm16));
    endcase
  end

  // Register file: reset to identity/zero, writeback independent of stall/flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= INIT_IDENTITY ? DATA_W'(i) : '0;
      end
    end else if (w_wr_commit) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Output entry: reset, then flush, then capture, then drain on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_rt_idx    <= 5'd0;
      r_rd_idx    <= 5'd0;
      r_ins       <= 32'd0;
      r_imm       <= '0;
      r_pc_plus4  <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_rd1       <= w_rd1;
      r_rd2       <= w_rd2;
      r_rt_idx    <= bus.instruction[20:16];
      r_rd_idx    <= bus.instruction[15:11];
      r_ins       <= bus.instruction;
      r_imm       <= w_imm;
      r_pc_plus4  <= bus.pc_plus4;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.rd1          = r_rd1;
  assign bus.rd2          = r_rd2;
  assign bus.rt_idx       = r_rt_idx;
  assign bus.rd_idx       = r_rd_idx;
  assign bus.ins_out      = r_ins;
  assign bus.imm_ext      = r_imm;
  assign bus.pc_plus4_out = r_pc_plus4;

endmodule
